// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use stall, data-memory wait FSM with timeout, branch flush.
// Optional build macro STALL_COUNT_EN adds a saturating stall_cycles counter port.
module hazard_stall_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_MemRead,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_bubble,
  output logic        exmem_write,
  output logic        memwb_bubble,
  output logic        mem_error,
`ifdef STALL_COUNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        o_dbg_state
);

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_error;

  logic w_load_use;
  logic w_freeze;
  logic w_hold_front;

  assign w_load_use = ex_MemRead && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

  // Handshake: mem_req marks an access in MEM; the access completes in the cycle
  // mem_ready is high. Until then the whole pipeline is frozen. The cycle right
  // after a timeout is never frozen so the aborted instruction moves on.
  always_comb begin
    w_freeze = 1'b0;
    if (r_state == IDLE)
      w_freeze = mem_req && !mem_ready && !r_mem_error;
    else
      w_freeze = !mem_ready;
  end

  // A taken branch discards the ID instruction, so it cancels a load-use hold.
  assign w_hold_front = w_load_use && !branch_taken;

  assign pc_write     = !w_freeze && !w_hold_front;
  assign ifid_write   = !w_freeze && !w_hold_front;
  assign ifid_flush   = !w_freeze && branch_taken;
  assign idex_write   = !w_freeze;
  assign idex_bubble  = !w_freeze && (branch_taken || w_load_use);
  assign exmem_write  = !w_freeze;
  assign memwb_bubble = w_freeze;
  assign mem_error    = r_mem_error;
  assign o_dbg_state  = (r_state == MEM_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_mem_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_freeze) begin
            r_state <= MEM_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_C) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef STALL_COUNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cycles <= '0;
    else if (!pc_write && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (MEM_TIMEOUT=4): load-use, memory wait,
// timeout, branch priority and reset-during-wait, with hand-computed output vectors.
module tb_hazard_stall_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_MemRead;
  logic       mem_req, mem_ready, branch_taken;
  logic       pc_write, ifid_write, ifid_flush, idex_write;
  logic       idex_bubble, exmem_write, memwb_bubble, mem_error;
  logic       dbg_state;
`ifdef STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble, mem_error}
  localparam logic [7:0] V_DEF  = 8'b1101_0100;
  localparam logic [7:0] V_ERR  = 8'b1101_0101;
  localparam logic [7:0] V_LU   = 8'b0001_1100;
  localparam logic [7:0] V_BR   = 8'b1111_1100;
  localparam logic [7:0] V_FRZ  = 8'b0000_0010;

  hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_MemRead   (ex_MemRead),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .exmem_write  (exmem_write),
    .memwb_bubble (memwb_bubble),
    .mem_error    (mem_error),
`ifdef STALL_COUNT_EN
    .stall_cycles (stall_cycles),
`endif
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers: inputs change on the falling edge, outputs are sampled 1 time unit later
  task automatic step(input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic req, input logic rdy, input logic br);
    @(negedge clk);
    ex_MemRead = mr; ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1;
    id_rs2 = rs2; id_use_rs2 = u2;
    mem_req = req; mem_ready = rdy; branch_taken = br;
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mem_step(input logic rdy, input logic br);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, rdy, br);
  endtask

  // checkers
  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pc_write, ifid_write, ifid_flush, idex_write,
           idex_bubble, exmem_write, memwb_bubble, mem_error};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic exp);
    checks++;
    assert (dbg_state === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, dbg_state, exp);
    end
  endtask

`ifdef STALL_COUNT_EN
  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    checks++;
    assert (stall_cycles === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, stall_cycles, exp);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    ex_MemRead = 0; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 0;
    id_rs2 = 0; id_use_rs2 = 0; mem_req = 0; mem_ready = 0; branch_taken = 0;
    #1;
    chk("reset_outputs", V_DEF);
    chk_state("reset_state", 1'b0);
`ifdef STALL_COUNT_EN
    chk_cnt("reset_stall_cycles", 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // 3-cycle memory wait, released in the 4th cycle
    mem_step(1'b0, 1'b0); chk("wait_c1", V_FRZ);
    mem_step(1'b0, 1'b0); chk("wait_c2", V_FRZ); chk_state("wait_state", 1'b1);
    mem_step(1'b0, 1'b0); chk("wait_c3", V_FRZ);
    mem_step(1'b1, 1'b0); chk("wait_release", V_DEF);
    idle_step();          chk("wait_after", V_DEF); chk_state("wait_idle", 1'b0);

    // load-use via rs1, then bubble in EX clears it
    step(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("lu_rs1", V_LU);
    step(1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); chk("lu_next", V_DEF);
`ifdef STALL_COUNT_EN
    chk_cnt("stall_cycles_4", 32'd4);
`endif
    step(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); chk("lu_rs2", V_LU);

    // no false stalls
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); chk("no_stall_rd0", V_DEF);
    step(1'b1, 5'd5, 5'd5, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); chk("no_stall_nouse", V_DEF);
    step(1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); chk("no_stall_noload", V_DEF);

    // single-cycle access
    mem_step(1'b1, 1'b0); chk("mem_single", V_DEF);

    // branch alone and branch over load-use
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); chk("branch", V_BR);
    step(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); chk("branch_over_lu", V_BR);

    // branch held during freeze, acted on when released
    mem_step(1'b0, 1'b1); chk("br_frz1", V_FRZ);
    mem_step(1'b0, 1'b1); chk("br_frz2", V_FRZ);
    mem_step(1'b1, 1'b1); chk("br_release", V_BR);
    idle_step();          chk("br_after", V_DEF);

    // timeout with MEM_TIMEOUT=4: five frozen cycles, then a released error cycle
    for (int i = 0; i < 5; i++) begin
      mem_step(1'b0, 1'b0); chk($sformatf("tmo_frz%0d", i), V_FRZ);
    end
    mem_step(1'b0, 1'b0); chk("tmo_error", V_ERR); chk_state("tmo_idle", 1'b0);
    idle_step();          chk("tmo_pulse_end", V_DEF);

    // reset while waiting at cnt=2
    mem_step(1'b0, 1'b0); chk("rst_frz1", V_FRZ);
    mem_step(1'b0, 1'b0); chk("rst_frz2", V_FRZ);
    @(negedge clk);
    rst_n = 1'b0; mem_req = 1'b0;
    #1;
    chk("rst_mid_wait", V_DEF);
    chk_state("rst_mid_state", 1'b0);
`ifdef STALL_COUNT_EN
    chk_cnt("rst_stall_cycles", 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle_step(); chk("rst_after", V_DEF);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Stall and flush controller for the 5-stage pipeline. Where forwarding supplies a late operand to an earlier stage, this block covers the cases forwarding cannot resolve:
- load-use hazards, by holding IF/ID and inserting an ID/EX bubble;
- multi-cycle data-memory accesses, by freezing the pipeline through a wait FSM with timeout;
- taken branches, by flushing the younger stages.

It sits beside the forwarding logic and drives the write-enables and flushes of the PC and all pipeline registers.

Parameters:
MEM_TIMEOUT, 15, max cycles waiting for mem_ready before abort; legal range 1..255.
CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
id_rs1  in  5  rs1 of instruction in ID.
id_rs2  in  5  rs2 of instruction in ID.
id_use_rs1  in  1  ID instruction reads rs1.
id_use_rs2  in  1  ID instruction reads rs2.
ex_rd  in  5  destination of instruction in EX.
ex_MemRead  in  1  EX instruction is a load.
mem_req  in  1  MEM-stage instruction accesses data memory this cycle.
mem_ready  in  1  data memory completes access this cycle.
branch_taken  in  1  EX resolved a taken branch or jump.
pc_write  out  1  PC update enable.
ifid_write  out  1  IF/ID register enable.
ifid_flush  out  1  IF/ID cleared to NOP.
idex_write  out  1  ID/EX register enable.
idex_bubble  out  1  ID/EX control fields zeroed.
exmem_write  out  1  EX/MEM register enable.
memwb_bubble  out  1  MEM/WB control fields zeroed (no writeback).
mem_error  out  1  one-cycle pulse on memory timeout.

Behaviour:
- FSM states: IDLE, MEM_WAIT. The wait counter cnt is CNT_W bits. Outputs are combinational from state and inputs (Mealy); mem_error is registered.
- Reset (rst_n=0, async):
  - state=IDLE, cnt=0, mem_error=0.
  - Outputs then follow the IDLE equations. With all inputs 0: pc_write=ifid_write=idex_write=exmem_write=1, all flush and bubble outputs 0.
- Default (IDLE, no hazard): all write enables 1, all flush and bubble outputs 0.
- Load-use:
  - Hazard = ex_MemRead && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - On hazard: pc_write=0, ifid_write=0, idex_bubble=1, same cycle.
  - Exactly one stall cycle results. Next cycle EX holds the bubble, so the condition clears and the operand is forwarded from MEM/WB.
- Memory wait:
  - In IDLE with mem_req=1 and mem_ready=0: freeze this cycle. Freeze means pc_write=ifid_write=idex_write=exmem_write=0 and memwb_bubble=1.
  - Next state MEM_WAIT, cnt<=1.
- In MEM_WAIT the freeze continues every cycle:
  - mem_ready=1: outputs return to the default (unfrozen) values that cycle, then state<=IDLE, cnt<=0.
  - mem_ready=0 and cnt==MEM_TIMEOUT: state<=IDLE, cnt<=0, mem_error<=1 for one cycle. The pipeline is released; the MEM instruction proceeds with undefined load data.
  - Otherwise cnt<=cnt+1. cnt never wraps.
- mem_req=1 with mem_ready=1 in IDLE: no stall (single-cycle access).
- Branch:
  - branch_taken=1: ifid_flush=1, idex_bubble=1; PC loads the target (pc_write=1).
  - Branch flush overrides a simultaneous load-use stall, because the ID instruction is discarded.
- Priority: memory freeze > branch flush > load-use stall.
  - During a freeze, ifid_flush=0 and idex_bubble=0.
  - A branch_taken held in frozen EX/MEM is acted on in the first unfrozen cycle.
- rst_n asserted mid-MEM_WAIT: immediate return to IDLE, cnt=0, no mem_error.
- ex_rd==0 never causes a stall.

Optional Feature:
STALL_COUNT_EN. When defined:
- Adds output port stall_cycles, 32 bits: a counter incremented on every clock edge where pc_write==0, saturating at 32'hFFFFFFFF.
- Async reset to 0.
When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle, with ex_MemRead=0, all defaults.
- No false stall: same as above but ex_rd=0, or id_use_rs1=0 -> pc_write=1, idex_bubble=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> freeze for 3 cycles, release in the 4th; mem_error stays 0.
- Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready held 0 -> freeze for 5 cycles, then mem_error=1 for exactly one cycle, state IDLE, pipeline released.
- Priority: branch_taken=1 together with load-use -> ifid_flush=1, idex_bubble=1, pc_write=1. branch_taken=1 during MEM_WAIT -> ifid_flush=0 until mem_ready.
- Reset: rst_n pulsed low during MEM_WAIT at cnt=2 -> immediate IDLE, defaults, mem_error=0. With STALL_COUNT_EN, stall_cycles=0 after reset and equals 4 after the 3-cycle wait plus one load-use stall.
